// File: rtl/mult_booth_seq_pkg.sv
// Shared definitions for the sequential Booth multiplier: datapath width,
// FSM state encoding and the radix-2 Booth operation decode.
package mult_booth_seq_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int COUNT_WIDTH = 5;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_e;

  // Radix-2 Booth recoding of the current multiplier bit and the guard bit.
  function automatic booth_op_e booth_decode(input logic mq0, input logic q1);
    booth_op_e op;
    case ({mq0, q1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mult_booth_seq_csa.sv
// 32-bit carry-select adder built from four 8-bit blocks. Each block
// precomputes its sum for carry-in 0 and 1; the incoming carry picks one.
module mult_booth_seq_csa (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] w_sum;
  logic        w_cout;

  // Evaluate both candidate sums per block and select along the carry chain.
  always_comb begin
    logic       c;
    logic [8:0] s0;
    logic [8:0] s1;
    c     = i_cin;
    w_sum = {32{1'b0}};
    for (int g = 0; g < 4; g++) begin
      s0 = {1'b0, i_a[g*8 +: 8]} + {1'b0, i_b[g*8 +: 8]};
      s1 = {1'b0, i_a[g*8 +: 8]} + {1'b0, i_b[g*8 +: 8]} + 9'd1;
      if (c) begin
        w_sum[g*8 +: 8] = s1[7:0];
        c               = s1[8];
      end else begin
        w_sum[g*8 +: 8] = s0[7:0];
        c               = s0[8];
      end
    end
    w_cout = c;
  end

  assign o_sum  = w_sum;
  assign o_cout = w_cout;

endmodule

// File: rtl/mult_booth_seq.sv
// Multi-cycle signed 32x32 radix-2 Booth multiplier. One Booth step per
// cycle through a single shared carry-select adder; returns the low 32 bits
// of the product and a signed-overflow flag with a one-cycle valid pulse.
module mult_booth_seq #(
  parameter int DATA_WIDTH  = mult_booth_seq_pkg::DATA_WIDTH,
  parameter int COUNT_WIDTH = mult_booth_seq_pkg::COUNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow
);

  import mult_booth_seq_pkg::*;

  logic [1:0]             r_state;
  logic                   r_in_ready;
  logic                   r_result_valid;
  logic [DATA_WIDTH-1:0]  r_result;
  logic                   r_overflow;
  logic [DATA_WIDTH-1:0]  r_mcand;
  logic [DATA_WIDTH:0]    r_acc;
  logic [DATA_WIDTH-1:0]  r_mq;
  logic                   r_q1;
  logic [COUNT_WIDTH-1:0] r_count;

  booth_op_e              w_op;
  logic [DATA_WIDTH-1:0]  w_addend;
  logic                   w_addend_msb;
  logic                   w_cin;
  logic [DATA_WIDTH-1:0]  w_add_sum;
  logic                   w_add_cout;
  logic [DATA_WIDTH:0]    w_sum;
  logic [DATA_WIDTH:0]    w_acc_next;
  logic [DATA_WIDTH-1:0]  w_mq_next;
  logic                   w_q1_next;
  logic                   w_ovf_next;

  // Select the adder operand: zero, the multiplicand, or its inversion for
  // subtraction (the +1 comes in through carry-in). The msb is the 33rd
  // bit of the sign-extended operand.
  always_comb begin
    w_op = booth_decode(r_mq[0], r_q1);
    case (w_op)
      BOOTH_ADD: begin
        w_addend     = r_mcand;
        w_addend_msb = r_mcand[DATA_WIDTH-1];
        w_cin        = 1'b0;
      end
      BOOTH_SUB: begin
        w_addend     = ~r_mcand;
        w_addend_msb = ~r_mcand[DATA_WIDTH-1];
        w_cin        = 1'b1;
      end
      default: begin
        w_addend     = {DATA_WIDTH{1'b0}};
        w_addend_msb = 1'b0;
        w_cin        = 1'b0;
      end
    endcase
  end

  mult_booth_seq_csa u_adder (
    .i_a    (r_acc[DATA_WIDTH-1:0]),
    .i_b    (w_addend),
    .i_cin  (w_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  // Extend the sum to 33 bits, then arithmetic-shift {sum,mq,q_1} right by one.
  always_comb begin
    w_sum      = {r_acc[DATA_WIDTH] ^ w_addend_msb ^ w_add_cout, w_add_sum};
    w_acc_next = {w_sum[DATA_WIDTH], w_sum[DATA_WIDTH:1]};
    w_mq_next  = {w_sum[0], r_mq[DATA_WIDTH-1:1]};
    w_q1_next  = r_mq[0];
    w_ovf_next = (w_acc_next[DATA_WIDTH-1:0] != {DATA_WIDTH{w_mq_next[DATA_WIDTH-1]}});
  end

  // Control FSM and datapath registers. The final step's shifted values are
  // captured straight into result/overflow so they are valid in DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_in_ready     <= 1'b1;
      r_result_valid <= 1'b0;
      r_result       <= {DATA_WIDTH{1'b0}};
      r_overflow     <= 1'b0;
      r_mcand        <= {DATA_WIDTH{1'b0}};
      r_acc          <= {(DATA_WIDTH+1){1'b0}};
      r_mq           <= {DATA_WIDTH{1'b0}};
      r_q1           <= 1'b0;
      r_count        <= {COUNT_WIDTH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_result_valid <= 1'b0;
          if (in_valid) begin
            r_mcand    <= operand_a;
            r_acc      <= {(DATA_WIDTH+1){1'b0}};
            r_mq       <= operand_b;
            r_q1       <= 1'b0;
            r_count    <= {COUNT_WIDTH{1'b0}};
            r_state    <= ST_BUSY;
            r_in_ready <= 1'b0;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_BUSY: begin
          r_acc   <= w_acc_next;
          r_mq    <= w_mq_next;
          r_q1    <= w_q1_next;
          r_count <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
          if (r_count == {COUNT_WIDTH{1'b1}}) begin
            r_state        <= ST_DONE;
            r_result       <= w_mq_next;
            r_overflow     <= w_ovf_next;
            r_result_valid <= 1'b1;
          end else begin
            r_result_valid <= 1'b0;
          end
        end
        ST_DONE: begin
          r_result_valid <= 1'b0;
          r_in_ready     <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_result_valid <= 1'b0;
          r_in_ready     <= 1'b1;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign result_valid = r_result_valid;
  assign result       = r_result;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed self-checking bench for mult_booth_seq: latency, handshake,
// signed products with hand-computed expectations, reset abort, held in_valid.
module tb_mult_booth_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        result_valid;
  logic [31:0] result;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  mult_booth_seq dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .result_valid (result_valid),
    .result       (result),
    .overflow     (overflow)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one operation from IDLE (called on a falling edge) and watch 40 cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_o, input string tag);
    int          first;
    int          pulses;
    int          ready_bad;
    logic        ready34;
    logic [31:0] got_r;
    logic        got_o;
    first = 0; pulses = 0; ready_bad = 0; ready34 = 1'b0;
    got_r = 32'h0; got_o = 1'b0;
    operand_a = a; operand_b = b; in_valid = 1'b1;
    @(negedge clock);
    in_valid  = 1'b0;
    operand_a = 32'hA5A5_5A5A;
    operand_b = 32'h5A5A_A5A5;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (result_valid) begin
        pulses++;
        if (first == 0) begin
          first = cyc; got_r = result; got_o = overflow;
        end
      end
      if (cyc <= 33 && in_ready) ready_bad++;
      if (cyc == 34) ready34 = in_ready;
      @(negedge clock);
    end
    check({tag, "_latency"}, 32'(first), 32'd33);
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_result"}, got_r, exp_r);
    check({tag, "_ovf"}, 32'(got_o), 32'(exp_o));
    check({tag, "_busy_ready"}, 32'(ready_bad), 32'd0);
    check({tag, "_ready34"}, 32'(ready34), 32'd1);
    check({tag, "_hold"}, result, exp_r);
  endtask

  initial begin
    int          pulses;
    int          accepts;
    int          acc_cyc;
    int          c1;
    int          c2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        rdy11;
    logic        rdy12;

    reset = 1'b1; in_valid = 1'b0; operand_a = 32'h0; operand_b = 32'h0;
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op(32'd3,         32'd5,         32'h0000_000F, 1'b0, "p3x5");
    run_op(32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 1'b0, "m7x6");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "minxm1");
    run_op(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "p2_32");
    run_op(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, "zero");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "m1xm1");
    run_op(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "minxmin");
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, "maxxmax");

    // Reset during BUSY aborts the operation.
    pulses = 0; rdy11 = 1'b0; rdy12 = 1'b0;
    operand_a = 32'd3; operand_b = 32'd5; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (result_valid) pulses++;
      if (cyc == 11) rdy11 = in_ready;
      if (cyc == 12) rdy12 = in_ready;
      if (cyc == 10) reset = 1'b1;
      if (cyc == 11) reset = 1'b0;
      @(negedge clock);
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_ready11", 32'(rdy11), 32'd1);
    check("abort_ready12", 32'(rdy12), 32'd1);
    check("abort_result", result, 32'h0);
    check("abort_ovf", 32'(overflow), 32'd0);
    run_op(32'd2, 32'd2, 32'd4, 1'b0, "post_rst");

    // in_valid held high; operands change mid-BUSY.
    pulses = 0; accepts = 0; acc_cyc = 0; c1 = 0; c2 = 0; r1 = 32'h0; r2 = 32'h0;
    operand_a = 32'd2; operand_b = 32'd3; in_valid = 1'b1;
    @(negedge clock);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (result_valid) begin
        pulses++;
        if (pulses == 1) begin c1 = cyc; r1 = result; end
        else if (pulses == 2) begin c2 = cyc; r2 = result; end
      end
      if (in_ready && in_valid) begin accepts++; acc_cyc = cyc; end
      if (cyc == 5) begin operand_a = 32'd4; operand_b = 32'd4; end
      if (cyc == 35) in_valid = 1'b0;
      @(negedge clock);
    end
    check("held_first_cyc", 32'(c1), 32'd33);
    check("held_first_res", r1, 32'd6);
    check("held_second_cyc", 32'(c2), 32'd67);
    check("held_second_res", r2, 32'd16);
    check("held_pulses", 32'(pulses), 32'd2);
    check("held_accepts", 32'(accepts), 32'd1);
    check("held_accept_cyc", 32'(acc_cyc), 32'd34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_booth_seq.md
Name: mult_booth_seq

Overview:
- Multi-cycle signed 32x32 multiplier for the SimpleALU datapath.
- Sits directly upstream of the ALU result mux. Time-shares one 32-bit carry-select adder for every partial-product add or subtract, using radix-2 Booth recoding.
- Accepts operands over a valid/ready handshake. Returns the low 32 bits of the product plus an overflow flag after a fixed latency.

Parameters:
DATA_WIDTH, 32, operand/result width; only 32 is supported because the adder is fixed at 32 bits
COUNT_WIDTH, 5, iteration counter width; must satisfy 2^COUNT_WIDTH == DATA_WIDTH

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands (high only in IDLE)
operand_a  input  32  multiplicand, two's complement
operand_b  input  32  multiplier, two's complement
result_valid  output  1  one-cycle pulse: result/overflow are fresh
result  output  32  low 32 bits of the signed product
overflow  output  1  product does not fit in signed 32 bits

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - State goes to IDLE; in_ready=1, result_valid=0, result=0, overflow=0.
  - acc, mq, q_1, count and the latched multiplicand all go to 0.
- Registers:
  - mcand[31:0] holds the latched multiplicand.
  - acc[32:0] is the 33-bit accumulator.
  - mq[31:0] holds the multiplier/low product; q_1 is the Booth guard bit.
  - count[COUNT_WIDTH-1:0] is the iteration counter.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a clock edge: mcand<=operand_a, acc<=0, mq<=operand_b, q_1<=0, count<=0, go to BUSY.
  - Operands are sampled only on that edge; later changes are ignored.
- BUSY (in_ready=0), one Booth step per cycle:
  - {mq[0],q_1}=01: sum = acc + sext33(mcand).
  - {mq[0],q_1}=10: sum = acc - sext33(mcand), computed as acc + ~sext33(mcand) with cin=1.
  - 00 or 11: sum = acc.
  - The adder's low 32 bits come straight from the adder. Bit 32 = acc[32] ^ operand_bit32 ^ adder_cout.
  - Then arithmetic-shift {sum,mq,q_1} right by 1 into {acc,mq,q_1}; count<=count+1.
  - When the step taken has count==31, go to DONE.
- DONE (in_ready=0), lasting one cycle:
  - result<=mq and overflow<=(acc[31:0] != {32{mq[31]}}) are registered on the entry edge.
  - result_valid=1 for exactly this cycle; then go to IDLE.
- Latency:
  - Accept edge at cycle 0; BUSY covers cycles 1..32; result_valid is high in cycle 33.
  - Next accept is possible at the end of cycle 34, giving a 34-cycle issue interval.
- result and overflow hold their values until the next DONE or reset.
- in_valid while not in IDLE is ignored: no queuing, no error.
- Reset mid-operation aborts: no result_valid is produced, and in_ready=1 in the cycle after reset deasserts.
- Edge operands (each must match the true signed product):
  - Most negative x -1: 0x80000000 x 0xFFFFFFFF gives result 0x80000000, overflow=1.
  - Zero operands give 0, overflow=0.

Decomposition:
- Shared ALU package holds:
  - the DATA_WIDTH constant;
  - state encoding IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - Booth op encoding NOP/ADD/SUB.
- One sub-module: the team's existing 32-bit carry-select adder, instantiated once. All arithmetic goes through it; there is no behavioural "+" on the datapath.
- The 33rd sum bit and the operand inversion mux are local logic.

Test Plan:
- operand_a=3, operand_b=5, one-cycle in_valid -> result_valid exactly at cycle 33; result=0x0000000F, overflow=0; in_ready low in cycles 1..33.
- operand_a=0xFFFFFFF9 (-7), operand_b=6 -> result=0xFFFFFFD6 (-42), overflow=0.
- operand_a=0x80000000, operand_b=0xFFFFFFFF -> result=0x80000000, overflow=1. Also operand_a=0x00010000, operand_b=0x00010000 -> result=0, overflow=1.
- operand_a=0x7FFFFFFF, operand_b=0x7FFFFFFF -> result=0x00000001, overflow=1. Also operand_a=0, operand_b=0x80000000 -> result=0, overflow=0.
- Accept 3x5, assert reset for one cycle at cycle 10 -> no result_valid ever, result=0. in_ready=1 in the cycle after reset; a new 2x2 then yields result=4 at +33.
- in_valid held high with 2x3 then operands changed to 4x4 mid-BUSY -> first result=6 at cycle 33. Second accept at the end of cycle 34 takes 4x4, result=16 at cycle 67; no extra accepts occur.
